piece_move_sched: RTL and testbench

Sequences the falling-piece datapath during play. Arbitrates between gravity drops and keyboard moves, and issues move, lock and spawn requests to the board logic over req/ack handshakes. Tracks cleared lines and level, and raises `endgame` for the game-state FSM when a spawn is blocked. Sits between the keyboard/vsync sources and the board/collision datapath.

---
 rtl/tetris_pkg.sv | 63 ++++++
 rtl/gravity_timer.sv | 53 +++++
 rtl/piece_move_sched.sv | 190 +++++++++++++++++++
 tb/tb_piece_move_sched.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
//------------------------------------------------------------------------------
// Module  : tetris_pkg
// Brief   : Shared types, keycodes and key decoding for the piece scheduler.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tetris_pkg;

  typedef enum logic [1:0] {
    OP_LEFT  = 2'd0,
    OP_RIGHT = 2'd1,
    OP_ROT   = 2'd2,
    OP_DOWN  = 2'd3
  } mv_op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_WAIT  = 3'd2,
    S_MOVE  = 3'd3,
    S_HDROP = 3'd4,
    S_LOCK  = 3'd5,
    S_OVER  = 3'd6
  } sched_state_t;

  localparam logic [15:0] KEY_LEFT  = 16'h0050;
  localparam logic [15:0] KEY_RIGHT = 16'h004F;
  localparam logic [15:0] KEY_ROT   = 16'h0052;
  localparam logic [15:0] KEY_DOWN  = 16'h0051;
  localparam logic [15:0] KEY_HARD  = 16'h002C;
  localparam logic [15:0] KEY_ENTER = 16'h0028;

  localparam logic [1:0] GAMESTATE_GAME = 2'd2;

  typedef struct packed {
    logic   valid;
    logic   hard;
    mv_op_t op;
  } key_dec_t;

  function automatic key_dec_t decode_key(input logic [15:0] code);
    key_dec_t d;
    d.valid = 1'b1;
    d.hard  = 1'b0;
    d.op    = OP_LEFT;
    case (code)
      KEY_LEFT:  d.op = OP_LEFT;
      KEY_RIGHT: d.op = OP_RIGHT;
      KEY_ROT:   d.op = OP_ROT;
      KEY_DOWN:  d.op = OP_DOWN;
      KEY_HARD: begin
        d.hard = 1'b1;
        d.op   = OP_DOWN;
      end
      default:   d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gravity_timer.sv
//------------------------------------------------------------------------------
// Module  : gravity_timer
// Brief   : Frame-tick countdown whose period shrinks with level; pulses drop_due.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gravity_timer #(
  parameter int GRAVITY_INIT = 48,
  parameter int GRAVITY_MIN  = 4,
  parameter int LEVEL_STEP   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_level,
  input  logic       i_enable,
  input  logic       i_tick,
  input  logic       i_reload,
  input  logic       i_init,
  output logic       o_drop_due
);

  localparam int CNT_W = $clog2(GRAVITY_INIT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_period;
  logic             w_drop_due;
  int               w_sub;

  // Signed int arithmetic keeps the clamp correct once the subtraction goes negative.
  always_comb begin
    w_sub = LEVEL_STEP * int'(i_level);
    if (GRAVITY_INIT - w_sub > GRAVITY_MIN)
      w_period = CNT_W'(GRAVITY_INIT - w_sub);
    else
      w_period = CNT_W'(GRAVITY_MIN);
  end

  assign w_drop_due = i_enable && i_tick && (r_cnt <= CNT_W'(1));
  assign o_drop_due = w_drop_due;

  always_ff @(posedge clk) begin
    if (!rst_n || i_init)
      r_cnt <= CNT_W'(GRAVITY_INIT);
    else if (i_reload)
      r_cnt <= w_period;
    else if (i_enable && i_tick)
      r_cnt <= w_drop_due ? w_period : r_cnt - CNT_W'(1);
  end

endmodule

`default_nettype wire

// File: rtl/piece_move_sched.sv
//------------------------------------------------------------------------------
// Module  : piece_move_sched
// Brief   : Arbitrates gravity and key moves; drives move/lock/spawn handshakes.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module piece_move_sched
  import tetris_pkg::*;
#(
  parameter int GRAVITY_INIT = 48,
  parameter int GRAVITY_MIN  = 4,
  parameter int LEVEL_STEP   = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [1:0]  gamestate,
  input  logic        reset_game,
  input  logic        frame_tick,
  input  logic [15:0] keycode,
  output logic        mv_req,
  output logic [1:0]  mv_op,
  input  logic        mv_ack,
  input  logic        mv_ok,
  output logic        lock_req,
  input  logic        lock_ack,
  input  logic [2:0]  lines_cleared,
  output logic        spawn_req,
  input  logic        spawn_ack,
  input  logic        spawn_ok,
  output logic        endgame,
  output logic [3:0]  level,
  output logic [9:0]  lines_total
);

  sched_state_t r_state;
  logic         r_mv_req, r_lock_req, r_spawn_req, r_endgame;
  mv_op_t       r_mv_op;
  logic [3:0]   r_level;
  logic [9:0]   r_lines;
  logic [15:0]  r_key_prev;
  logic         r_key_pend, r_key_hard, r_grav_pend, r_grav_served;
  mv_op_t       r_key_op;

  key_dec_t     w_key;
  logic         w_key_new, w_drop_due, w_grav_reload, w_grav_en;
  logic [10:0]  w_lines_sum;
  logic [9:0]   w_div;
  logic [3:0]   w_level_next;

  assign w_key       = decode_key(keycode);
  assign w_key_new   = w_key.valid && (keycode != r_key_prev);
  assign w_lines_sum = {1'b0, r_lines} + {8'd0, lines_cleared};
  assign w_div       = r_lines / 10'd10;
  assign w_level_next = (w_div > 10'd15) ? 4'd15 : w_div[3:0];

  assign w_grav_en     = (r_state == S_WAIT) && !reset_game;
  assign w_grav_reload = ((r_state == S_SPAWN) && r_spawn_req && spawn_ack && spawn_ok) ||
                         ((r_state == S_MOVE) && r_mv_req && mv_ack &&
                          (r_mv_op == OP_DOWN) && mv_ok);

  gravity_timer #(
    .GRAVITY_INIT (GRAVITY_INIT),
    .GRAVITY_MIN  (GRAVITY_MIN),
    .LEVEL_STEP   (LEVEL_STEP)
  ) u_gravity_timer (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .i_level    (r_level),
    .i_enable   (w_grav_en),
    .i_tick     (frame_tick),
    .i_reload   (w_grav_reload),
    .i_init     (reset_game),
    .o_drop_due (w_drop_due)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state       <= S_IDLE;
      r_mv_req      <= 1'b0;
      r_mv_op       <= OP_LEFT;
      r_lock_req    <= 1'b0;
      r_spawn_req   <= 1'b0;
      r_endgame     <= 1'b0;
      r_level       <= 4'd0;
      r_lines       <= 10'd0;
      // Capturing the live code means a key held through reset does not fire.
      r_key_prev    <= keycode;
      r_key_pend    <= 1'b0;
      r_key_op      <= OP_LEFT;
      r_key_hard    <= 1'b0;
      r_grav_pend   <= 1'b0;
      r_grav_served <= 1'b0;
    end else begin
      r_key_prev <= keycode;
      r_level    <= w_level_next;
      if (w_drop_due)
        r_grav_pend <= 1'b1;
      if (reset_game) begin
        r_state     <= S_IDLE;
        r_mv_req    <= 1'b0;
        r_lock_req  <= 1'b0;
        r_spawn_req <= 1'b0;
        r_endgame   <= 1'b0;
        r_level     <= 4'd0;
        r_lines     <= 10'd0;
        r_key_pend  <= 1'b0;
        r_grav_pend <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (gamestate == GAMESTATE_GAME) r_state <= S_SPAWN;
          S_SPAWN: begin
            if (!r_spawn_req) begin
              r_spawn_req <= 1'b1;
            end else if (spawn_ack) begin
              r_spawn_req <= 1'b0;
              if (spawn_ok) begin
                r_key_pend  <= 1'b0;
                r_grav_pend <= 1'b0;
                r_state     <= S_WAIT;
              end else begin
                r_endgame <= 1'b1;
                r_state   <= S_OVER;
              end
            end
          end
          S_WAIT: begin
            // A key is consumed when dequeued, so presses during the handshake queue up.
            if (r_key_pend) begin
              r_key_pend    <= 1'b0;
              r_grav_served <= 1'b0;
              r_mv_req      <= 1'b1;
              r_mv_op       <= r_key_hard ? OP_DOWN : r_key_op;
              r_state       <= r_key_hard ? S_HDROP : S_MOVE;
            end else if (r_grav_pend) begin
              r_grav_served <= 1'b1;
              r_mv_req      <= 1'b1;
              r_mv_op       <= OP_DOWN;
              r_state       <= S_MOVE;
            end
          end
          S_MOVE: begin
            if (r_mv_req && mv_ack) begin
              r_mv_req <= 1'b0;
              if (r_grav_served)
                r_grav_pend <= 1'b0;
              r_state <= ((r_mv_op == OP_DOWN) && !mv_ok) ? S_LOCK : S_WAIT;
            end
          end
          S_HDROP: begin
            if (!r_mv_req) begin
              r_mv_req <= 1'b1;
            end else if (mv_ack) begin
              r_mv_req <= 1'b0;
              if (!mv_ok)
                r_state <= S_LOCK;
            end
          end
          S_LOCK: begin
            if (!r_lock_req) begin
              r_lock_req <= 1'b1;
            end else if (lock_ack) begin
              r_lock_req <= 1'b0;
              r_lines    <= w_lines_sum[10] ? 10'd1023 : w_lines_sum[9:0];
              r_state    <= S_SPAWN;
            end
          end
          S_OVER:  r_endgame <= 1'b1;
          default: r_state <= S_IDLE;
        endcase
        if (w_key_new) begin
          r_key_pend <= 1'b1;
          r_key_op   <= w_key.op;
          r_key_hard <= w_key.hard;
        end
      end
    end
  end

  assign mv_req      = r_mv_req;
  assign mv_op       = r_mv_op;
  assign lock_req    = r_lock_req;
  assign spawn_req   = r_spawn_req;
  assign endgame     = r_endgame;
  assign level       = r_level;
  assign lines_total = r_lines;

endmodule

`default_nettype wire

// File: tb/tb_piece_move_sched.sv
//------------------------------------------------------------------------------
// Module  : tb_piece_move_sched
// Brief   : Scoreboard bench for piece_move_sched with a game-level model.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_piece_move_sched;
  import tetris_pkg::*;

  localparam int P_INIT = 48;
  localparam int P_MIN  = 4;
  localparam int P_STEP = 4;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [1:0]  gamestate = 2'd0;
  logic        reset_game = 1'b0;
  logic        frame_tick = 1'b0;
  logic [15:0] keycode = 16'd0;
  logic        mv_req, lock_req, spawn_req, endgame;
  logic [1:0]  mv_op;
  logic        mv_ack = 1'b0, mv_ok = 1'b0, lock_ack = 1'b0, spawn_ack = 1'b0, spawn_ok = 1'b0;
  logic [2:0]  lines_cleared = 3'd0;
  logic [3:0]  level;
  logic [9:0]  lines_total;

  always #5 Clk = ~Clk;

  piece_move_sched #(
    .GRAVITY_INIT (P_INIT),
    .GRAVITY_MIN  (P_MIN),
    .LEVEL_STEP   (P_STEP)
  ) dut (
    .Clk (Clk), .Reset_n (Reset_n), .gamestate (gamestate), .reset_game (reset_game),
    .frame_tick (frame_tick), .keycode (keycode),
    .mv_req (mv_req), .mv_op (mv_op), .mv_ack (mv_ack), .mv_ok (mv_ok),
    .lock_req (lock_req), .lock_ack (lock_ack), .lines_cleared (lines_cleared),
    .spawn_req (spawn_req), .spawn_ack (spawn_ack), .spawn_ok (spawn_ok),
    .endgame (endgame), .level (level), .lines_total (lines_total)
  );

  // kind: 0 move, 1 lock, 2 spawn; ok/lines are the responses the datapath returns
  typedef struct { int kind; int op; int ok; int lines; } txn_t;
  txn_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_lines = 0;
  bit   mon_en   = 1'b0;
  bit   mon_busy = 1'b0;

  function automatic int m_level();
    return (m_lines / 10 > 15) ? 15 : m_lines / 10;
  endfunction

  function automatic int m_period(input int lvl);
    int p;
    p = P_INIT - P_STEP * lvl;
    return (p < P_MIN) ? P_MIN : p;
  endfunction

  function automatic logic req_of(input int k);
    return (k == 0) ? mv_req : (k == 1) ? lock_req : spawn_req;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_txn(input int kind, input int op, input int ok, input int lines);
    txn_t t;
    t.kind = kind; t.op = op; t.ok = ok; t.lines = lines;
    exp_q.push_back(t);
  endtask

  task automatic model_lock(input int lines, input int spawn_good);
    expect_txn(1, 0, 0, lines);
    m_lines = (m_lines + lines > 1023) ? 1023 : m_lines + lines;
    expect_txn(2, 0, spawn_good, 0);
  endtask

  task automatic press(input logic [15:0] k);
    @(negedge Clk) keycode = k;
    @(negedge Clk) keycode = 16'd0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (n >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d transactions outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge Clk);
  endtask

  task automatic check_stats();
    check("lines_total", int'(lines_total), m_lines);
    check("level", int'(level), m_level());
  endtask

  task automatic check_reset_outs();
    check("rst_mv_req", int'(mv_req), 0);
    check("rst_mv_op", int'(mv_op), 0);
    check("rst_lock_req", int'(lock_req), 0);
    check("rst_spawn_req", int'(spawn_req), 0);
    check("rst_endgame", int'(endgame), 0);
    check("rst_level", int'(level), 0);
    check("rst_lines_total", int'(lines_total), 0);
  endtask

  task automatic wait_req(input int kind, input string name);
    int n;
    n = 0;
    while (!req_of(kind) && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check(name, int'(req_of(kind)), 1);
  endtask

  task automatic grav_test(input int exp_period);
    int got;
    got = -1;
    expect_txn(0, int'(OP_DOWN), 1, 0);
    for (int i = 1; i <= exp_period + 3; i++) begin
      @(negedge Clk) frame_tick = 1'b1;
      @(negedge Clk) frame_tick = 1'b0;
      repeat (2) @(negedge Clk);
      if (exp_q.size() == 0) begin
        got = i;
        break;
      end
    end
    check("grav_period", got, exp_period);
    drain(100);
  endtask

  task automatic quick_lock(input int lines);
    expect_txn(0, int'(OP_DOWN), 0, 0);
    model_lock(lines, 1);
    press(KEY_DOWN);
    drain(200);
  endtask

  task automatic random_step();
    int sel, ok, ln, n;
    bit locked;
    sel = $urandom_range(0, 4);
    ok  = $urandom_range(0, 1);
    ln  = $urandom_range(0, 4);
    locked = 1'b0;
    case (sel)
      0: begin expect_txn(0, int'(OP_LEFT), ok, 0);  press(KEY_LEFT);  end
      1: begin expect_txn(0, int'(OP_RIGHT), ok, 0); press(KEY_RIGHT); end
      2: begin expect_txn(0, int'(OP_ROT), ok, 0);   press(KEY_ROT);   end
      3: begin
        expect_txn(0, int'(OP_DOWN), ok, 0);
        if (ok == 0) begin model_lock(ln, 1); locked = 1'b1; end
        press(KEY_DOWN);
      end
      default: begin
        n = $urandom_range(0, 3);
        repeat (n) expect_txn(0, int'(OP_DOWN), 1, 0);
        expect_txn(0, int'(OP_DOWN), 0, 0);
        model_lock(ln, 1);
        locked = 1'b1;
        press(KEY_HARD);
      end
    endcase
    drain(300);
    if (locked) check_stats();
  endtask

  // Monitor: pops the expected handshake whenever a request appears and answers it.
  initial begin : monitor
    txn_t t;
    int   kind, op0;
    forever begin
      @(negedge Clk);
      if (mon_en && (mv_req || lock_req || spawn_req)) begin
        mon_busy = 1'b1;
        kind = mv_req ? 0 : (lock_req ? 1 : 2);
        op0  = int'(mv_op);
        check("req_onehot", int'(mv_req) + int'(lock_req) + int'(spawn_req), 1);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_req: kind %0d op %0d seen, expected none", kind, op0);
          t.kind = kind; t.op = op0; t.ok = 1; t.lines = 0;
        end else begin
          t = exp_q.pop_front();
          check("req_kind", kind, t.kind);
          if (t.kind == 0 && kind == 0) check("mv_op", op0, t.op);
        end
        repeat ($urandom_range(0, 2)) begin
          @(negedge Clk);
          check("req_hold", int'(req_of(kind)), 1);
          if (kind == 0) check("op_stable", int'(mv_op), op0);
        end
        case (kind)
          0:       begin mv_ok = (t.ok != 0); mv_ack = 1'b1; end
          1:       begin lines_cleared = 3'(t.lines); lock_ack = 1'b1; end
          default: begin spawn_ok = (t.ok != 0); spawn_ack = 1'b1; end
        endcase
        @(negedge Clk);
        mv_ack = 1'b0; lock_ack = 1'b0; spawn_ack = 1'b0;
        check("req_drop", int'(req_of(kind)), 0);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int seen;
    repeat (3) @(negedge Clk);
    check_reset_outs();
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    check("idle_no_spawn", int'(spawn_req), 0);

    // Start of game
    mon_en = 1'b1;
    expect_txn(2, 0, 1, 0);
    gamestate = GAMESTATE_GAME;
    drain(50);

    // Key-to-request latency
    expect_txn(0, int'(OP_LEFT), 1, 0);
    @(negedge Clk) keycode = KEY_LEFT;
    @(negedge Clk) check("key_lat1", int'(mv_req), 0);
    keycode = 16'd0;
    @(negedge Clk) check("key_lat2", int'(mv_req), 1);
    drain(50);

    grav_test(m_period(0));

    // Key and gravity expiry on the same cycle: key first, then gravity DOWN
    expect_txn(0, int'(OP_LEFT), 1, 0);
    expect_txn(0, int'(OP_DOWN), 1, 0);
    for (int i = 1; i < m_period(0); i++) begin
      @(negedge Clk) frame_tick = 1'b1;
      @(negedge Clk) frame_tick = 1'b0;
    end
    @(negedge Clk) begin frame_tick = 1'b1; keycode = KEY_LEFT; end
    @(negedge Clk) begin frame_tick = 1'b0; keycode = 16'd0; end
    drain(100);

    // Hard drop: three good DOWNs, then blocked, lock with 4 lines
    repeat (3) expect_txn(0, int'(OP_DOWN), 1, 0);
    expect_txn(0, int'(OP_DOWN), 0, 0);
    model_lock(4, 1);
    press(KEY_HARD);
    drain(200);
    check_stats();

    // Held key fires once
    expect_txn(0, int'(OP_RIGHT), 0, 0);
    @(negedge Clk) keycode = KEY_RIGHT;
    repeat (20) @(negedge Clk);
    keycode = 16'd0;
    drain(50);

    for (int i = 0; i < 30; i++) random_step();

    // Restart back to IDLE
    gamestate = 2'd0;
    @(negedge Clk) reset_game = 1'b1;
    @(negedge Clk) reset_game = 1'b0;
    m_lines = 0;
    seen = 0;
    repeat (5) begin @(negedge Clk); seen = seen | int'(spawn_req); end
    check("restart_idle", seen, 0);
    check_stats();
    expect_txn(2, 0, 1, 0);
    gamestate = GAMESTATE_GAME;
    drain(50);

    // Level ramp and gravity period scaling
    quick_lock(4); quick_lock(4); quick_lock(1);
    check_stats();
    quick_lock(1);
    check_stats();
    grav_test(m_period(m_level()));
    while (m_lines < 150) quick_lock(4);
    check_stats();
    grav_test(m_period(m_level()));
    for (int i = 0; i < 220; i++) quick_lock(4);
    check_stats();

    // Game over
    expect_txn(0, int'(OP_DOWN), 0, 0);
    model_lock(0, 0);
    press(KEY_DOWN);
    drain(100);
    check("endgame_set", int'(endgame), 1);
    repeat (10) @(negedge Clk);
    check("endgame_hold", int'(endgame), 1);
    check("over_no_spawn", int'(spawn_req), 0);

    gamestate = 2'd0;
    @(negedge Clk) reset_game = 1'b1;
    @(negedge Clk) reset_game = 1'b0;
    m_lines = 0;
    @(negedge Clk);
    check("endgame_clr", int'(endgame), 0);
    check_stats();

    // Restart while a move request is outstanding
    expect_txn(2, 0, 1, 0);
    gamestate = GAMESTATE_GAME;
    drain(50);
    mon_en = 1'b0;
    press(KEY_LEFT);
    wait_req(0, "mv_req_pending");
    gamestate = 2'd0;
    reset_game = 1'b1;
    @(negedge Clk) reset_game = 1'b0;
    check("restart_drops_mv", int'(mv_req), 0);
    mv_ok = 1'b1; mv_ack = 1'b1;
    @(negedge Clk) mv_ack = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge Clk); seen = seen | int'(mv_req) | int'(lock_req) | int'(spawn_req); end
    check("late_ack_quiet", seen, 0);
    mon_en = 1'b1;
    expect_txn(2, 0, 1, 0);
    gamestate = GAMESTATE_GAME;
    drain(50);
    grav_test(m_period(0));

    // Reset in the middle of a lock with a key held across it
    quick_lock(3);
    mon_en = 1'b0;
    press(KEY_DOWN);
    wait_req(0, "mv_req_before_lock");
    mv_ok = 1'b0; mv_ack = 1'b1;
    @(negedge Clk) mv_ack = 1'b0;
    wait_req(1, "lock_req_pending");
    keycode = KEY_ROT;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b0;
    m_lines = 0;
    expect_txn(2, 0, 1, 0);
    @(negedge Clk) Reset_n = 1'b1;
    check_reset_outs();
    mon_en = 1'b1;
    drain(50);
    repeat (10) @(negedge Clk);
    keycode = 16'd0;
    expect_txn(0, int'(OP_ROT), 1, 0);
    press(KEY_ROT);
    drain(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
